// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, funct fields,
// ALU/immediate/write-back selectors, trap causes, instruction classes and FSM states.
package multicycle_control_pkg;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_ALU     = 7'b0110011;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;
  localparam logic [2:0] FUNCT3_JALR = 3'b000;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [3:0] EXE_ADD_OP  = 4'd0;
  localparam logic [3:0] EXE_SUB_OP  = 4'd1;
  localparam logic [3:0] EXE_SLL_OP  = 4'd2;
  localparam logic [3:0] EXE_SLT_OP  = 4'd3;
  localparam logic [3:0] EXE_SLTU_OP = 4'd4;
  localparam logic [3:0] EXE_XOR_OP  = 4'd5;
  localparam logic [3:0] EXE_SRL_OP  = 4'd6;
  localparam logic [3:0] EXE_SRA_OP  = 4'd7;
  localparam logic [3:0] EXE_OR_OP   = 4'd8;
  localparam logic [3:0] EXE_AND_OP  = 4'd9;
  localparam logic [3:0] EXE_LUI_OP  = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  localparam logic [3:0] CLS_ALU     = 4'd0;
  localparam logic [3:0] CLS_ALU_IMM = 4'd1;
  localparam logic [3:0] CLS_LUI     = 4'd2;
  localparam logic [3:0] CLS_AUIPC   = 4'd3;
  localparam logic [3:0] CLS_JAL     = 4'd4;
  localparam logic [3:0] CLS_JALR    = 4'd5;
  localparam logic [3:0] CLS_BRANCH  = 4'd6;
  localparam logic [3:0] CLS_LOAD    = 4'd7;
  localparam logic [3:0] CLS_STORE   = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_t;

  // alt selects SUB/SRA; callers only raise it where funct7=0100000 is meaningful
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      FUNCT3_ADD:  return alt ? EXE_SUB_OP : EXE_ADD_OP;
      FUNCT3_SLL:  return EXE_SLL_OP;
      FUNCT3_SLT:  return EXE_SLT_OP;
      FUNCT3_SLTU: return EXE_SLTU_OP;
      FUNCT3_XOR:  return EXE_XOR_OP;
      FUNCT3_SR:   return alt ? EXE_SRA_OP : EXE_SRL_OP;
      FUNCT3_OR:   return EXE_OR_OP;
      default:     return EXE_AND_OP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_ctrl_decode.sv
// Combinational RV32I decoder: instruction word to class, ALU op, immediate format,
// memory size/sign and an illegal-encoding flag; zero latency, no flow control.
module multicycle_control_ctrl_decode
  import multicycle_control_pkg::*;
(
  input  logic [31:0] inst,
  output logic [3:0]  cls,
  output logic [3:0]  alu_op,
  output logic [2:0]  imm_sel,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opcode        = inst[6:0];
  assign f3            = inst[14:12];
  assign f7            = inst[31:25];
  assign unused_fields = ^{inst[24:15], inst[11:7]};

  always_comb begin
    cls          = CLS_ALU;
    alu_op       = EXE_ADD_OP;
    imm_sel      = IMM_I;
    mem_size     = f3[1:0];
    mem_unsigned = 1'b0;
    illegal      = 1'b0;
    case (opcode)
      OP_LUI: begin
        cls     = CLS_LUI;
        imm_sel = IMM_U;
        alu_op  = EXE_LUI_OP;
      end
      OP_AUIPC: begin
        cls     = CLS_AUIPC;
        imm_sel = IMM_U;
      end
      OP_JAL: begin
        cls     = CLS_JAL;
        imm_sel = IMM_J;
      end
      OP_JALR: begin
        cls     = CLS_JALR;
        illegal = (f3 != FUNCT3_JALR);
      end
      OP_BRANCH: begin
        cls     = CLS_BRANCH;
        imm_sel = IMM_B;
        illegal = (f3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        cls          = CLS_LOAD;
        mem_unsigned = f3[2];
        illegal      = (f3[1:0] == 2'b11) || (f3[2] && f3[1]);
      end
      OP_STORE: begin
        cls     = CLS_STORE;
        imm_sel = IMM_S;
        illegal = f3[2] || (f3[1:0] == 2'b11);
      end
      OP_ALU_IMM: begin
        cls    = CLS_ALU_IMM;
        // ADDI has no SUB form, so bit 30 of its immediate must not select one
        alu_op = alu_from_funct3(f3, (f3 == FUNCT3_SR) && f7[5]);
        if (f3 == FUNCT3_SLL)
          illegal = (f7 != FUNCT7_BASE);
        else if (f3 == FUNCT3_SR)
          illegal = (f7 != FUNCT7_BASE) && (f7 != FUNCT7_ALT);
      end
      OP_ALU: begin
        cls     = CLS_ALU;
        alu_op  = alu_from_funct3(f3, f7[5]);
        illegal = !((f7 == FUNCT7_BASE) ||
                    ((f7 == FUNCT7_ALT) && ((f3 == FUNCT3_ADD) || (f3 == FUNCT3_SR))));
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/writeback with timed memory handshake.
// Zero-wait latency: branch 3, store/ALU/jump 4, load 5 cycles; stalls on mem_ack, traps after MEM_TIMEOUT.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst,
  input  logic                 branch_taken,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [1:0]           mem_size,
  output logic                 mem_unsigned,
  output logic                 ir_write_en,
  output logic                 pc_write_en,
  output logic                 pc_sel,
  output logic [2:0]           imm_sel,
  output logic                 alu_s1_sel,
  output logic                 alu_s2_sel,
  output logic [3:0]           alu_op,
  output logic                 reg_write_en,
  output logic [1:0]           wb_sel,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [1:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] instret_q;

  logic [3:0] d_cls, d_alu_op;
  logic [2:0] d_imm_sel;
  logic [1:0] d_mem_size;
  logic       d_mem_unsigned, d_illegal;

  multicycle_control_ctrl_decode u_ctrl_decode (
    .inst         (inst),
    .cls          (d_cls),
    .alu_op       (d_alu_op),
    .imm_sel      (d_imm_sel),
    .mem_size     (d_mem_size),
    .mem_unsigned (d_mem_unsigned),
    .illegal      (d_illegal)
  );

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    cause_d      = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_size     = 2'b00;
    mem_unsigned = 1'b0;
    ir_write_en  = 1'b0;
    pc_write_en  = 1'b0;
    pc_sel       = 1'b0;
    imm_sel      = 3'd0;
    alu_s1_sel   = 1'b0;
    alu_s2_sel   = 1'b0;
    alu_op       = 4'd0;
    reg_write_en = 1'b0;
    wb_sel       = 2'b00;
    trap         = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_size = MEM_SIZE_WORD;
        if (mem_ack) begin
          ir_write_en = 1'b1;
          state_d     = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (d_illegal) begin
          state_d = S_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_op     = d_alu_op;
        imm_sel    = d_imm_sel;
        alu_s1_sel = (d_cls == CLS_ALU) || (d_cls == CLS_ALU_IMM) || (d_cls == CLS_JALR) ||
                     (d_cls == CLS_LOAD) || (d_cls == CLS_STORE);
        alu_s2_sel = (d_cls != CLS_ALU);
        if (d_cls == CLS_BRANCH) begin
          pc_write_en = 1'b1;
          pc_sel      = branch_taken;
          state_d     = S_FETCH;
        end else if ((d_cls == CLS_LOAD) || (d_cls == CLS_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_we       = (d_cls == CLS_STORE);
        mem_size     = d_mem_size;
        mem_unsigned = d_mem_unsigned;
        if (mem_ack) begin
          if (d_cls == CLS_STORE) begin
            pc_write_en = 1'b1;
            state_d     = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRITEBACK: begin
        reg_write_en = 1'b1;
        pc_write_en  = 1'b1;
        state_d      = S_FETCH;
        if (d_cls == CLS_LOAD) begin
          wb_sel = WB_MEM;
        end else if ((d_cls == CLS_JAL) || (d_cls == CLS_JALR)) begin
          // jump target was left in the ALU output register by EXECUTE
          wb_sel = WB_PC4;
          pc_sel = 1'b1;
        end else begin
          wb_sel = WB_ALU;
        end
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      cause_q   <= TRAP_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (pc_write_en)
        instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule
